pipelined_cla_addsub: RTL and testbench
=======================================

Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 32-bit combinational CLA adder.
- Operand width, CLA group size and pipeline depth are parameters. Adds a subtract mode, a valid/ready handshake with backpressure, and a sticky overflow flag.
- Sits in the datapath wherever a multi-cycle, high-fmax add/sub with signed-overflow reporting is needed.

Parameters:
- WIDTH, 32, operand/sum width in bits.
- BLOCK, 4, CLA group size in bits (generate/propagate group).
- STAGES, 2, pipeline register stages = latency in cycles. Requires STAGES>=1 and WIDTH % (STAGES*BLOCK) == 0.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A (two's complement).
- b  in  WIDTH  operand B (two's complement).
- cin  in  1  carry/borrow-in.
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  raw carry out of the MSB.
- of  out  1  signed overflow for this beat.
- of_sticky  out  1  set when any accepted result had of=1.
- clr_sticky  in  1  clears of_sticky.

Behaviour:
- Operation: beff = b ^ {WIDTH{sub}} and ceff = cin ^ sub.
  - sum = (a + beff + ceff) mod 2^WIDTH.
  - cout = bit WIDTH of that sum, never inverted. A subtract with no borrow gives cout=1.
  - of = carry into MSB XOR carry out of MSB.
- Datapath split:
  - SEG = WIDTH/STAGES. Stage k computes bits [k*SEG +: SEG] using a two-level CLA built from BLOCK-bit groups, with carry-in taken from stage k-1's registered carry. Stage 0 uses ceff.
  - Upper operand bits are skewed forward through the pipeline and completed sum bits are delayed, so all fields of a beat emerge aligned.
  - No ripple chain longer than BLOCK bits within a stage.
- Handshake:
  - The pipeline advances when adv = !out_valid || out_ready.
  - in_ready = adv (combinational from out_ready).
  - A beat is accepted when in_valid && in_ready.
  - Each stage carries its own valid bit, so bubbles propagate. Throughput is 1 beat/cycle when out_ready=1.
  - Latency is exactly STAGES cycles from acceptance to out_valid with no stall.
  - While out_valid && !out_ready, the whole pipeline freezes and sum/cout/of/out_valid hold stable. Beat order is always preserved.
- Sticky flag:
  - Set on a cycle with out_valid && out_ready && of.
  - clr_sticky clears it on the next edge.
  - Set and clear in the same cycle: set wins, flag stays 1.
- Reset (including mid-operation):
  - All stage valid bits, out_valid and of_sticky go to 0 on the next edge.
  - sum and cout go to 0; of goes to 0.
  - In-flight beats are discarded.
  - in_ready = 1 while out_valid = 0.
- Boundaries:
  - Full pipeline with out_ready=0: in_ready=0 and nothing is overwritten.
  - Empty pipeline: out_valid=0 and output data hold their last values (0 after reset).
  - Wrap-around is modulo 2^WIDTH with no saturation.
  - in_valid=0 inserts a bubble.

Test Plan (WIDTH=32, BLOCK=4, STAGES=2 unless noted):
1. a=7fffffff, b=7fffffff, cin=0, sub=0 -> 2 cycles later sum=fffffffe, cout=0, of=1; of_sticky=1 after acceptance.
2. Back-to-back beats on consecutive cycles:
   - beat 1: 8fffffff + 8fffffff -> sum=1ffffffe, cout=1, of=1.
   - beat 2: 000007aa + ffffffff -> sum=000007a9, cout=1, of=0.
   - beat 3: 000000af + 000000af with cin=1 -> sum=0000015f, cout=0, of=0.
   - Results appear on 3 consecutive cycles in order.
3. Subtract:
   - a=5, b=7, sub=1, cin=0 -> sum=fffffffe, cout=0, of=0.
   - a=80000000, b=1, sub=1 -> sum=7fffffff, cout=1, of=1.
4. Backpressure: fill the pipe, drop out_ready for 3 cycles -> in_ready=0, outputs frozen. Raise out_ready -> all beats drain in order, none lost or duplicated.
5. Reset mid-flight: 2 beats in the pipe, rst pulsed for 1 cycle -> out_valid=0 and of_sticky=0 after the edge; no stale beat emerges later.
6. Sticky clear coincident with an overflowing accepted beat -> of_sticky stays 1; clr_sticky alone -> 0. Then with WIDTH=8, STAGES=1: ff + 01 -> sum=00, cout=1, of=0, latency 1.

Source files
------------

// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: parametrised pipelined two-level CLA adder/subtractor with valid/ready and sticky overflow.
module pipelined_cla_addsub #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             of,
  output logic             of_sticky,
  input  logic             clr_sticky
);
  localparam int SEG = WIDTH / STAGES;
  localparam int NG  = SEG / BLOCK;

  // Returns {carry into segment MSB, segment carry out, segment sum}.
  function automatic logic [SEG+1:0] cla(input logic [SEG-1:0] x, input logic [SEG-1:0] y, input logic ci);
    logic [SEG-1:0] g, p, s;
    logic [NG-1:0] gg, gp;
    logic [NG:0] gc;
    logic c, t;
    g = x & y;
    p = x ^ y;
    s = '0;
    for (int j = 0; j < NG; j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
        gg[j] = g[j*BLOCK+i] | (p[j*BLOCK+i] & gg[j]);
        gp[j] = gp[j] & p[j*BLOCK+i];
      end
    end
    // Each group carry is an independent lookahead term from ci, not chained from its neighbour.
    gc[0] = ci;
    for (int j = 1; j <= NG; j++) begin
      t = ci;
      for (int i = 0; i < j; i++) t = gg[i] | (gp[i] & t);
      gc[j] = t;
    end
    for (int j = 0; j < NG; j++) begin
      c = gc[j];
      for (int i = 0; i < BLOCK; i++) begin
        s[j*BLOCK+i] = p[j*BLOCK+i] ^ c;
        c = g[j*BLOCK+i] | (p[j*BLOCK+i] & c);
      end
    end
    return {s[SEG-1] ^ p[SEG-1], gc[NG], s};
  endfunction

  logic             v_q [STAGES], v_d [STAGES], vi [STAGES];
  logic             c_q [STAGES], c_d [STAGES], ci [STAGES];
  logic             m_q [STAGES], m_d [STAGES];
  logic [WIDTH-1:0] a_q [STAGES], a_d [STAGES], ai [STAGES];
  logic [WIDTH-1:0] b_q [STAGES], b_d [STAGES], bi [STAGES];
  logic [WIDTH-1:0] s_q [STAGES], s_d [STAGES], si [STAGES];
  logic [SEG+1:0]   r;
  logic             adv, of_sticky_q;

  assign out_valid = v_q[STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign of        = c_q[STAGES-1] ^ m_q[STAGES-1];
  assign of_sticky = of_sticky_q;

  // Operands ride along in place so each stage slices its own segment; bubbles leave data untouched.
  always_comb begin
    vi[0] = in_valid;
    ci[0] = cin ^ sub;
    ai[0] = a;
    bi[0] = b ^ {WIDTH{sub}};
    si[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      vi[k] = v_q[k-1];
      ci[k] = c_q[k-1];
      ai[k] = a_q[k-1];
      bi[k] = b_q[k-1];
      si[k] = s_q[k-1];
    end
    r = '0;
    for (int k = 0; k < STAGES; k++) begin
      r = cla(ai[k][k*SEG +: SEG], bi[k][k*SEG +: SEG], ci[k]);
      v_d[k] = vi[k];
      c_d[k] = vi[k] ? r[SEG] : c_q[k];
      m_d[k] = vi[k] ? r[SEG+1] : m_q[k];
      a_d[k] = vi[k] ? ai[k] : a_q[k];
      b_d[k] = vi[k] ? bi[k] : b_q[k];
      s_d[k] = s_q[k];
      if (vi[k]) begin
        s_d[k] = si[k];
        s_d[k][k*SEG +: SEG] = r[SEG-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        m_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        c_q[k] <= c_d[k];
        m_q[k] <= m_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) of_sticky_q <= 1'b0;
    else of_sticky_q <= (out_valid && out_ready && of) || (of_sticky_q && !clr_sticky);
  end
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb_pipelined_cla_addsub: directed vectors with hand-computed results for the 32/4/2 and 8/4/1 configurations.
module tb_pipelined_cla_addsub;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0, sub = 1'b0, clr_sticky = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, of, of_sticky;
  logic [31:0] sum;
  logic        in_valid8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        in_ready8, out_valid8, cout8, of8, of_sticky8;
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  pipelined_cla_addsub #(.WIDTH(32), .BLOCK(4), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .of(of), .of_sticky(of_sticky), .clr_sticky(clr_sticky)
  );

  pipelined_cla_addsub #(.WIDTH(8), .BLOCK(4), .STAGES(1)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .cin(1'b0), .sub(1'b0), .out_valid(out_valid8), .out_ready(1'b1), .sum(sum8),
    .cout(cout8), .of(of8), .of_sticky(of_sticky8), .clr_sticky(1'b0)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic xc, input logic xs);
    in_valid = 1'b1;
    a = xa;
    b = xb;
    cin = xc;
    sub = xs;
    step();
  endtask

  task automatic expect_res(input string tag, input logic [31:0] s, input logic c, input logic o);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".sum"}, 64'(sum), 64'(s));
    chk({tag, ".cout"}, 64'(cout), 64'(c));
    chk({tag, ".of"}, 64'(of), 64'(o));
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.sum", 64'(sum), 64'd0);
    chk("rst.cout", 64'(cout), 64'd0);
    chk("rst.of", 64'(of), 64'd0);
    chk("rst.sticky", 64'(of_sticky), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);

    send(32'h7fffffff, 32'h7fffffff, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("t1.lat1", 64'(out_valid), 64'd0);
    step();
    expect_res("t1", 32'hfffffffe, 1'b0, 1'b1);
    chk("t1.sticky_pre", 64'(of_sticky), 64'd0);
    step();
    chk("t1.sticky", 64'(of_sticky), 64'd1);
    chk("t1.empty", 64'(out_valid), 64'd0);
    chk("t1.hold", 64'(sum), 64'hfffffffe);

    send(32'h8fffffff, 32'h8fffffff, 1'b0, 1'b0);
    send(32'h000007aa, 32'hffffffff, 1'b0, 1'b0);
    expect_res("t2.b1", 32'h1ffffffe, 1'b1, 1'b1);
    send(32'h000000af, 32'h000000af, 1'b1, 1'b0);
    expect_res("t2.b2", 32'h000007a9, 1'b1, 1'b0);
    in_valid = 1'b0;
    step();
    expect_res("t2.b3", 32'h0000015f, 1'b0, 1'b0);
    step();
    chk("t2.drained", 64'(out_valid), 64'd0);

    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    chk("clr.sticky", 64'(of_sticky), 64'd0);

    send(32'd5, 32'd7, 1'b0, 1'b1);
    send(32'h80000000, 32'd1, 1'b0, 1'b1);
    expect_res("t3.s1", 32'hfffffffe, 1'b0, 1'b0);
    in_valid = 1'b0;
    step();
    expect_res("t3.s2", 32'h7fffffff, 1'b1, 1'b1);
    step();

    send(32'd1, 32'd2, 1'b0, 1'b0);
    send(32'd10, 32'd20, 1'b0, 1'b0);
    a = 32'd100;
    b = 32'd200;
    out_ready = 1'b0;
    #1;
    chk("t4.in_ready_low", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_res("t4.frozen", 32'd3, 1'b0, 1'b0);
      chk("t4.in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("t4.in_ready_up", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    expect_res("t4.d2", 32'd30, 1'b0, 1'b0);
    step();
    expect_res("t4.d3", 32'd300, 1'b0, 1'b0);
    step();
    chk("t4.drained", 64'(out_valid), 64'd0);

    chk("t5.sticky_pre", 64'(of_sticky), 64'd1);
    send(32'h7fffffff, 32'd1, 1'b0, 1'b0);
    send(32'd2, 32'd2, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5.valid", 64'(out_valid), 64'd0);
    chk("t5.sticky", 64'(of_sticky), 64'd0);
    chk("t5.sum", 64'(sum), 64'd0);
    chk("t5.of", 64'(of), 64'd0);
    chk("t5.in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5.no_stale", 64'(out_valid), 64'd0);
    end

    send(32'h7fffffff, 32'd1, 1'b0, 1'b0);
    in_valid = 1'b0;
    step();
    expect_res("t6.ovf", 32'h80000000, 1'b0, 1'b1);
    clr_sticky = 1'b1;
    step();
    chk("t6.set_wins", 64'(of_sticky), 64'd1);
    step();
    clr_sticky = 1'b0;
    chk("t6.cleared", 64'(of_sticky), 64'd0);

    chk("w8.idle", 64'(out_valid8), 64'd0);
    in_valid8 = 1'b1;
    a8 = 8'hff;
    b8 = 8'h01;
    step();
    a8 = 8'h7f;
    chk("w8.v1", 64'(out_valid8), 64'd1);
    chk("w8.sum1", 64'(sum8), 64'h00);
    chk("w8.cout1", 64'(cout8), 64'd1);
    chk("w8.of1", 64'(of8), 64'd0);
    step();
    in_valid8 = 1'b0;
    chk("w8.sum2", 64'(sum8), 64'h80);
    chk("w8.cout2", 64'(cout8), 64'd0);
    chk("w8.of2", 64'(of8), 64'd1);
    step();
    chk("w8.empty", 64'(out_valid8), 64'd0);
    chk("w8.sticky", 64'(of_sticky8), 64'd1);
    chk("w8.in_ready", 64'(in_ready8), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
